// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: bundles the writeback taps, trace controls and drain port of the trace buffer.
// Latency: none, wires only.
// Backpressure: rd_ready from the drain consumer; the writeback taps never stall the core.
// Optional: TRACE_TIMESTAMP_EN widens rd_entry by a 32-bit cycle stamp.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int NCH   = 2,
  parameter int PC_W  = 32
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif
  localparam int ENTRY_W = CH_W + 5 + PC_W + XLEN + TS_W;

  logic [NCH-1:0]      wb_valid;
  logic [NCH*5-1:0]    wb_rd;
  logic [NCH*XLEN-1:0] wb_data;
  logic [PC_W-1:0]     wb_pc;
  logic                arm;
  logic                halt;
  logic                trig_en;
  logic [PC_W-1:0]     trig_pc;
  logic                rd_valid;
  logic                rd_ready;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [CNT_W-1:0]    count;
  logic [1:0]          state;
  logic                wrapped;

  modport master (
    output wb_valid, wb_rd, wb_data, wb_pc, arm, halt, trig_en, trig_pc, rd_ready,
    input  rd_valid, rd_entry, count, state, wrapped
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, wb_pc, arm, halt, trig_en, trig_pc, rd_ready,
    output rd_valid, rd_entry, count, state, wrapped
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: circular capture of retired int/float register writes, frozen by PC trigger or halt, drained oldest-first.
// Latency: writeback to stored 1 clk; pop to next rd_entry 1 clk, back-to-back pops supported.
// Backpressure: rd_entry held stable while rd_valid && !rd_ready; capture never stalls, the oldest entries are overwritten.
// Optional: TRACE_TIMESTAMP_EN appends a free-running 32-bit cycle stamp as the entry LSBs.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int XLEN      = 32,
  parameter int NCH       = 2,
  parameter int PC_W      = 32,
  parameter int POST_TRIG = 4
) (
  input logic              clk,
  input logic              rst,
  wb_trace_buffer_if.slave bus
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int KW    = $clog2(NCH + 1);
  localparam int PST_W = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam int AW    = (PST_W > KW) ? PST_W : KW;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif
  localparam int ENTRY_W = CH_W + 5 + PC_W + XLEN + TS_W;

  typedef enum logic [1:0] {
    idle   = 2'b00,
    armed  = 2'b01,
    post   = 2'b10,
    frozen = 2'b11
  } state_t;

  state_t             st, st_n;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               wrapped_q, wrapped_n;
  logic [PST_W-1:0]   post_cnt, post_n;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_entry_q;
  logic [ENTRY_W-1:0] head;

  logic               capture;
  logic [NCH-1:0]     we;
  logic [PTR_W-1:0]   waddr  [NCH];
  logic [ENTRY_W-1:0] wentry [NCH];
  logic [KW-1:0]      k;
  logic [CNT_W:0]     sum;
  logic [AW-1:0]      post_ext, k_ext;
  logic               trig_hit;
  logic               rd_valid_w;
  logic               pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts;

  // Free-running cycle stamp shared by every channel written in a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 32'd1;
  end
`endif

  assign capture    = (st == armed) || (st == post);
  assign trig_hit   = bus.trig_en && (|bus.wb_valid) && (bus.wb_pc == bus.trig_pc);
  assign rd_valid_w = (st == frozen) && (count_q != '0);
  assign pop        = rd_valid_w && bus.rd_ready;

  // Pack each channel's entry and pack valid channels onto consecutive slots in channel order.
  always_comb begin
    int acc;
    acc = 0;
    we  = '0;
    for (int i = 0; i < NCH; i++) begin
      we[i]    = capture && bus.wb_valid[i];
      waddr[i] = wr_ptr + PTR_W'(acc);
`ifdef TRACE_TIMESTAMP_EN
      wentry[i] = {CH_W'(i), bus.wb_rd[5*i +: 5], bus.wb_pc, bus.wb_data[XLEN*i +: XLEN], ts};
`else
      wentry[i] = {CH_W'(i), bus.wb_rd[5*i +: 5], bus.wb_pc, bus.wb_data[XLEN*i +: XLEN]};
`endif
      if (we[i]) acc = acc + 1;
    end
    k = KW'(acc);
  end

  // Next-state, pointer, occupancy and post-window bookkeeping.
  always_comb begin
    st_n      = st;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = count_q;
    wrapped_n = wrapped_q;
    post_n    = post_cnt;
    sum       = {1'b0, count_q} + (CNT_W+1)'(k);
    post_ext  = AW'(post_cnt);
    k_ext     = AW'(k);
    case (st)
      idle: begin
        // arm wins over a simultaneous halt; halt has no meaning here
        if (bus.arm) begin
          st_n      = armed;
          wr_ptr_n  = '0;
          rd_ptr_n  = '0;
          count_n   = '0;
          wrapped_n = 1'b0;
          post_n    = '0;
        end
      end
      armed, post: begin
        wr_ptr_n = wr_ptr + PTR_W'(k);
        if (sum > (CNT_W+1)'(DEPTH)) begin
          // overflow: drop the oldest entries by sliding the read pointer
          count_n   = CNT_W'(DEPTH);
          rd_ptr_n  = rd_ptr + PTR_W'(sum - (CNT_W+1)'(DEPTH));
          wrapped_n = 1'b1;
        end else begin
          count_n = CNT_W'(sum);
        end
        if (st == armed) begin
          if (bus.halt) begin
            st_n = frozen;
          end else if (trig_hit) begin
            if (POST_TRIG == 0) begin
              st_n = frozen;
            end else begin
              st_n   = post;
              post_n = PST_W'(POST_TRIG);
            end
          end
        end else begin
          // extra entries beyond the window in the last cycle are still kept
          post_n = (post_ext > k_ext) ? PST_W'(post_ext - k_ext) : '0;
          if (bus.halt || (post_ext <= k_ext)) st_n = frozen;
        end
      end
      frozen: begin
        if (count_q == '0) begin
          st_n = idle;
        end else if (pop) begin
          rd_ptr_n = rd_ptr + PTR_W'(1);
          count_n  = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) st_n = idle;
        end
      end
      default: st_n = idle;
    endcase
  end

  // Head of the buffer after this edge, forwarding a same-cycle write into that slot.
  always_comb begin
    head = mem[rd_ptr_n];
    for (int i = 0; i < NCH; i++) begin
      if (we[i] && (waddr[i] == rd_ptr_n)) head = wentry[i];
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= idle;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      post_cnt  <= '0;
    end else begin
      st        <= st_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count_q   <= count_n;
      wrapped_q <= wrapped_n;
      post_cnt  <= post_n;
    end
  end

  // Registered drain data; only reloaded while frozen so it cannot move under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rd_entry_q <= '0;
    else if (st_n == frozen) rd_entry_q <= head;
  end

  // Trace storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (we[i]) mem[waddr[i]] <= wentry[i];
    end
  end

  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_entry = rd_entry_q;
  assign bus.count    = count_q;
  assign bus.state    = st;
  assign bus.wrapped  = wrapped_q;
endmodule
